// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
//   Queues hold/reset/set/toggle commands and plays each one onto the J/K
//   inputs of a jk_flip_flop for a programmed number of clocks. A JK model
//   tracks the Q the flip-flop should hold. After every command the real Q is
//   compared against the model, and any disagreement is latched in a sticky
//   mismatch flag.
//
// Handshake (command port): a command {cmd_op, cmd_len} is taken on every
//   rising edge where cmd_valid && cmd_ready are both high. cmd_ready depends
//   only on queue occupancy, never on cmd_valid. A producer holding cmd_valid
//   while cmd_ready is low keeps its command; the command is taken on the
//   first edge where cmd_ready is high.
//
// Timing of one command of effective length N (N = cmd_len, or 1 if cmd_len is 0):
//   E0   command pushed into the queue
//   E1   popped in IDLE; J/K registered from the op; cnt = N
//   E2 .. E(1+N)   the flip-flop samples J/K and the model steps
//   E(1+N)         J/K return to 0; the FSM enters CHECK
//   CHECK          done is high for one cycle; Q is compared at the next edge
//   Back-to-back commands leave two J=K=0 cycles (CHECK and IDLE) between
//   their drive windows.

module jk_cmd_sequencer #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  input  logic             q_in,
  output logic             exp_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [1:0]       state_dbg
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                FILL_W    = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic [1:0]       op_mem  [FIFO_DEPTH];
  logic [CNT_W-1:0] len_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FILL_W-1:0] fill;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;
  logic [CNT_W-1:0] head_cnt;

  assign fifo_full  = (fill == FILL_FULL);
  assign fifo_empty = (fill == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head_op    = op_mem[rd_ptr];
  assign head_len   = len_mem[rd_ptr];
  // A zero length still drives the flip-flop for one clock.
  assign head_cnt   = (head_len == '0) ? CNT_ONE : head_len;

  // Store an accepted command at the write pointer (payload needs no reset).
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      len_mem[wr_ptr] <= cmd_len;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and datapath
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  // cnt never reaches 0 inside DRIVE; "<=" keeps the exit safe regardless.
  assign cnt_last = (cnt <= CNT_ONE);

  // JK next-state model: 00 keep, 01 clear, 10 set, 11 invert.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, queue pop and the done strobe.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_last) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // J/K drive, cycle counter, expected-Q model and the sticky mismatch flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      J        <= 1'b0;
      K        <= 1'b0;
      cnt      <= '0;
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          J <= 1'b0;
          K <= 1'b0;
          if (pop) begin
            J   <= head_op[1];
            K   <= head_op[0];
            cnt <= head_cnt;
          end
        end
        ST_DRIVE: begin
          // The flip-flop samples the J/K held during this cycle at this edge,
          // so the model steps with the same values.
          cnt   <= cnt - CNT_ONE;
          exp_q <= jk_next(exp_q, J, K);
          if (cnt_last) begin
            J <= 1'b0;
            K <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (q_in != exp_q) begin
            mismatch <= 1'b1;
          end
        end
        default: begin
          J <= 1'b0;
          K <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer
//   Drives jk_cmd_sequencer against a behavioural JK flip-flop (with a
//   stuck-at-0 option for Q). A table of single commands is replayed with
//   hand-computed drive lengths and final Q, followed by hand-written
//   sequences for queue back-pressure, sticky mismatch and mid-command reset.

module tb_jk_cmd_sequencer;

  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             j_w;
  logic             k_w;
  logic             q_in;
  logic             exp_q_w;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [1:0]       state_dbg;

  jk_cmd_sequencer #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .J         (j_w),
    .K         (k_w),
    .q_in      (q_in),
    .exp_q     (exp_q_w),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .state_dbg (state_dbg)
  );

  // Behavioural flip-flop sharing clk/reset with the sequencer.
  logic ff_q;
  logic stuck_lo;
  always @(posedge clk) begin
    if (reset) ff_q <= 1'b0;
    else begin
      case ({j_w, k_w})
        2'b00:   ff_q <= ff_q;
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        default: ff_q <= ~ff_q;
      endcase
    end
  end
  assign q_in = stuck_lo ? 1'b0 : ff_q;

  // ---------------------------------------------------------------------------
  // Scoreboard: expected drive windows {op, length} in command order
  // ---------------------------------------------------------------------------
  int         n_vec = 0;
  int         n_bad = 0;
  int         done_total = 0;
  logic [9:0] sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Window monitor: reconstructs each J/K drive window and pops the scoreboard.
  logic       in_win = 1'b0;
  logic [1:0] win_op;
  int         win_len;
  logic [9:0] mon_want;
  logic [9:0] mon_got;
  always @(posedge clk) begin
    #2;
    if (done) done_total++;
    if (reset) begin
      in_win = 1'b0;
    end else if ({j_w, k_w} != 2'b00) begin
      if (!in_win) begin
        in_win  = 1'b1;
        win_op  = {j_w, k_w};
        win_len = 1;
      end else begin
        win_len++;
      end
    end else if (in_win) begin
      in_win = 1'b0;
      if (sb_q.size() == 0) begin
        chk("unexpected drive window", 1, 0);
      end else begin
        mon_want = sb_q.pop_front();
        mon_got  = {win_op, win_len[7:0]};
        chk("drive window op/len", int'(mon_got), int'(mon_want));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until taken; returns the cycles stalled.
  task automatic push_cmd(input logic [1:0] op, input logic [7:0] len, output int stall);
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    stall     = 0;
    while (!cmd_ready && stall < 100) begin
      step();
      stall++;
    end
    step();
  endtask

  // Run one command on an idle sequencer and check its whole life cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] len, input int drive,
                         input int hi, input logic fin_q, input logic mm_pre,
                         input logic mm_post, input string tag);
    int   stall, first_hi, hi_cnt, done_cyc, bad_jk;
    logic q_done, mm_done;
    if (hi > 0) sb_q.push_back({op, hi[7:0]});
    push_cmd(op, len, stall);
    cmd_valid = 1'b0;
    chk({tag, " accept stall"}, stall, 0);
    first_hi = -1;
    hi_cnt   = 0;
    done_cyc = -1;
    bad_jk   = 0;
    q_done   = 1'b0;
    mm_done  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ({j_w, k_w} != 2'b00) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
        if ({j_w, k_w} != op) bad_jk++;
      end
      if (done) begin
        done_cyc = i;
        q_done   = exp_q_w;
        mm_done  = mismatch;
        break;
      end
      step();
    end
    if (hi > 0) chk({tag, " first drive cycle"}, first_hi, 1);
    chk({tag, " drive cycles"}, hi_cnt, hi);
    chk({tag, " J/K value"}, bad_jk, 0);
    chk({tag, " done cycle"}, done_cyc, drive + 1);
    chk({tag, " exp_q at done"}, int'(q_done), int'(fin_q));
    chk({tag, " mismatch at done"}, int'(mm_done), int'(mm_pre));
    step();
    chk({tag, " done width"}, int'(done), 0);
    chk({tag, " mismatch after"}, int'(mismatch), int'(mm_post));
    chk({tag, " exp_q idle"}, int'(exp_q_w), int'(fin_q));
    chk({tag, " busy idle"}, int'(busy), 0);
    chk({tag, " J/K idle"}, int'({j_w, k_w}), 0);
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    sb_q.delete();
    repeat (2) step();
    chk({tag, " J"}, int'(j_w), 0);
    chk({tag, " K"}, int'(k_w), 0);
    chk({tag, " exp_q"}, int'(exp_q_w), 0);
    chk({tag, " cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " mismatch"}, int'(mismatch), 0);
    chk({tag, " done"}, int'(done), 0);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: op, len, effective drive length, J/K-high cycles, final Q
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] op;
    logic [7:0] len;
    int         drive;
    int         hi;
    logic       fin_q;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int stall, d0, wait_cyc, act_cnt;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    stuck_lo  = 1'b0;

    vecs[0] = '{op: 2'b10, len: 8'd3,   drive: 3,   hi: 3,   fin_q: 1'b1};
    vecs[1] = '{op: 2'b11, len: 8'd5,   drive: 5,   hi: 5,   fin_q: 1'b0};
    vecs[2] = '{op: 2'b11, len: 8'd0,   drive: 1,   hi: 1,   fin_q: 1'b1};
    vecs[3] = '{op: 2'b00, len: 8'd4,   drive: 4,   hi: 0,   fin_q: 1'b1};
    vecs[4] = '{op: 2'b01, len: 8'd2,   drive: 2,   hi: 2,   fin_q: 1'b0};
    vecs[5] = '{op: 2'b00, len: 8'd1,   drive: 1,   hi: 0,   fin_q: 1'b0};
    vecs[6] = '{op: 2'b11, len: 8'd2,   drive: 2,   hi: 2,   fin_q: 1'b0};
    vecs[7] = '{op: 2'b10, len: 8'd1,   drive: 1,   hi: 1,   fin_q: 1'b1};
    vecs[8] = '{op: 2'b11, len: 8'd255, drive: 255, hi: 255, fin_q: 1'b0};
    vecs[9] = '{op: 2'b00, len: 8'd0,   drive: 1,   hi: 0,   fin_q: 1'b0};

    // Reset state.
    reset_check("t1 reset");

    // Single commands from the table.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].drive, vecs[i].hi, vecs[i].fin_q,
              1'b0, 1'b0, $sformatf("v%0d", i));
    end

    // Q stuck at 0: mismatch rises after the SET check and stays set.
    stuck_lo = 1'b1;
    run_cmd(2'b10, 8'd2, 2, 2, 1'b1, 1'b0, 1'b1, "t5 set");
    run_cmd(2'b01, 8'd1, 1, 1, 1'b0, 1'b1, 1'b1, "t5 reset");
    stuck_lo = 1'b0;
    reset_check("t5 clear");

    // Five pushes while a len=10 command runs; the queue fills at four.
    d0 = done_total;
    sb_q.push_back({2'b11, 8'd10});
    sb_q.push_back({2'b10, 8'd2});
    sb_q.push_back({2'b01, 8'd3});
    sb_q.push_back({2'b11, 8'd1});
    sb_q.push_back({2'b10, 8'd4});
    sb_q.push_back({2'b11, 8'd2});
    push_cmd(2'b11, 8'd10, stall);
    chk("t4 push A stall", stall, 0);
    push_cmd(2'b10, 8'd2, stall);
    chk("t4 push B stall", stall, 0);
    push_cmd(2'b01, 8'd3, stall);
    chk("t4 push C stall", stall, 0);
    push_cmd(2'b11, 8'd1, stall);
    chk("t4 push D stall", stall, 0);
    push_cmd(2'b10, 8'd4, stall);
    chk("t4 push E stall", stall, 0);
    chk("t4 ready when full", int'(cmd_ready), 0);
    chk("t4 busy when full", int'(busy), 1);
    push_cmd(2'b11, 8'd2, stall);
    cmd_valid = 1'b0;
    chk("t4 push F stall", stall, 9);
    wait_cyc = 0;
    while (busy && wait_cyc < 300) begin
      step();
      wait_cyc++;
    end
    chk("t4 drain timeout", int'(busy), 0);
    chk("t4 done pulses", done_total - d0, 6);
    chk("t4 final exp_q", int'(exp_q_w), 1);
    chk("t4 final q_in", int'(q_in), 1);
    chk("t4 mismatch", int'(mismatch), 0);
    chk("t4 scoreboard left", sb_q.size(), 0);

    // Reset in the middle of a drive window with two commands queued.
    push_cmd(2'b10, 8'd20, stall);
    push_cmd(2'b11, 8'd3, stall);
    push_cmd(2'b01, 8'd3, stall);
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("t6 J mid drive", int'(j_w), 1);
    chk("t6 exp_q mid drive", int'(exp_q_w), 1);
    chk("t6 busy mid drive", int'(busy), 1);
    reset = 1'b1;
    sb_q.delete();
    d0 = done_total;
    step();
    chk("t6 J after reset", int'(j_w), 0);
    chk("t6 K after reset", int'(k_w), 0);
    chk("t6 busy after reset", int'(busy), 0);
    chk("t6 exp_q after reset", int'(exp_q_w), 0);
    chk("t6 ready after reset", int'(cmd_ready), 1);
    chk("t6 state after reset", int'(state_dbg), 0);
    reset = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({j_w, k_w} != 2'b00 || busy) act_cnt++;
    end
    chk("t6 no activity after flush", act_cnt, 0);
    chk("t6 no done pulse", done_total - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
